lbm_phase_sequencer: RTL and testbench
======================================

LBM_PHASE_SEQUENCER -- requirements
Module: lbm_phase_sequencer

Interface
REQ-001 Parameter: WIDTH, 64, lattice columns.
REQ-002 Parameter: HEIGHT, 32, lattice rows; DEPTH = WIDTH*HEIGHT.
REQ-003 Parameter: STEP_W, 16, timestep counter width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  clock, rising edge.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: start  in  1  run request, sampled in IDLE only.
REQ-008 Port: num_steps  in  STEP_W  timesteps to run, latched on accepted start.
REQ-009 Port: dp_ready  in  1  datapath accepts current cell.
REQ-010 Port: dp_idle  in  1  datapath pipeline empty.
REQ-011 Port: barrier_in  in  1  barrier bit of the cell at cell_index.
REQ-012 Port: busy  out  1  run in progress.
REQ-013 Port: done  out  1  one-cycle run-complete pulse.
REQ-014 Port: phase  out  3  IDLE=0, STREAM=1, BOUNCE=2, ZERO=3, COLLIDE=4.
REQ-015 Port: cell_valid  out  1  cell_index is presented to the datapath.
REQ-016 Port: cell_index  out  ADDRESS_WIDTH  linear cell address, row*WIDTH+col.
REQ-017 Port: row, col  out  clog2(HEIGHT), clog2(WIDTH)  coordinates of cell_index.
REQ-018 Port: at_top, at_bottom, at_left, at_right  out  1 each  row==0, row==HEIGHT-1, col==0, col==WIDTH-1.
REQ-019 Port: step_count  out  STEP_W  completed timesteps in the current run.

Function
REQ-020 Each timestep SHALL sweep STREAM, BOUNCE, ZERO, COLLIDE in order, visiting cell 0..DEPTH-1 ascending.
REQ-021 row/col SHALL be held as separate counters: col wraps WIDTH-1->0 and increments row; no divide or modulo.
REQ-022 Cell handshake: cell_valid=1 with cell_index; advance only on cell_valid&&dp_ready; cell_index and cell_valid SHALL remain stable while dp_ready=0.
REQ-023 Start accepted in cycle N: busy=1, phase=STREAM, cell_index=0, and cell_valid=1 in cycle N+1.
REQ-024 After the last-cell handshake, drain: cell_valid=0 and phase unchanged until dp_idle=1 is sampled (minimum 1 cycle).
REQ-025 Drain exit SHALL enter the next phase at cell 0 in the following cycle.
REQ-026 COLLIDE drain exit SHALL increment step_count; if the result equals the latched num_steps, return to IDLE with busy=0 and done=1 for one cycle; otherwise enter STREAM.
REQ-027 num_steps=0: done pulse in cycle N+1; no cell_valid; busy stays 0.
REQ-028 start while busy SHALL be ignored; num_steps changes while busy SHALL be ignored.
REQ-029 Edge flags SHALL be combinational from row/col and valid whenever cell_valid=1.
REQ-030 step_count SHALL clear on accepted start and hold its value in IDLE after done.

Reset
REQ-031 rst_n low SHALL immediately force phase=IDLE, busy=0, done=0, cell_valid=0, cell_index=0, row=0, col=0, step_count=0, at any point including mid-sweep.
REQ-032 After reset release, no activity occurs until a new start.

Configuration
REQ-033 Macro LBM_BARRIER_SKIP_EN defined: in BOUNCE and ZERO, cells with barrier_in=0 SHALL advance one per cycle without asserting cell_valid; only barrier cells are handshaken.
REQ-034 Macro undefined: barrier_in SHALL be ignored and every phase presents all DEPTH cells.

Structure
REQ-035 The phase encoding typedef and the WIDTH/HEIGHT/DEPTH/ADDRESS_WIDTH constants SHALL live in the shared LBM package.
REQ-036 One sub-module, lbm_cell_counter (index/row/col counters with advance, clear, and last-cell flag), SHALL be instantiated.

Verification (WIDTH=4, HEIGHT=3, DEPTH=12)
REQ-037 num_steps=1, dp_ready=1, dp_idle=1, start in cycle 0 -> STREAM in cycles 1-12, drain in 13, BOUNCE 14-25, ZERO 27-38, COLLIDE 40-51, done=1 and busy=0 in cycle 53, step_count=1.
REQ-038 dp_ready=0 for 3 cycles while cell_index=5 -> cell_index held at 5 with cell_valid=1 for 4 cycles, then advances to 6.
REQ-039 cell_index=7 -> row=1, col=3, at_right=1, at_top=at_bottom=at_left=0.
REQ-040 num_steps=0 -> done pulse in cycle 1, cell_valid never asserted.
REQ-041 rst_n low during BOUNCE at cell_index=6 -> all outputs at reset values in the same cycle; no activity after release until start.
REQ-042 LBM_BARRIER_SKIP_EN, barrier only at cell 5 -> BOUNCE and ZERO each assert cell_valid once, with cell_index=5; STREAM and COLLIDE each assert it 12 times.

Source files
------------

// File: rtl/lbm_phase_sequencer_pkg.sv
// Shared LBM package: lattice geometry constants, phase encoding and small
// helpers used by the phase sequencer and its cell counter.
package lbm_phase_sequencer_pkg;

   localparam int LBM_WIDTH         = 64;
   localparam int LBM_HEIGHT        = 32;
   localparam int LBM_DEPTH         = LBM_WIDTH * LBM_HEIGHT;
   localparam int LBM_ADDRESS_WIDTH = $clog2(LBM_DEPTH);

   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_STREAM  = 3'd1,
      PH_BOUNCE  = 3'd2,
      PH_ZERO    = 3'd3,
      PH_COLLIDE = 3'd4
   } phase_e;

   // Keeps single-row/column lattices from producing zero-width counters.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic phase_e next_phase(input phase_e p);
      case (p)
         PH_STREAM: return PH_BOUNCE;
         PH_BOUNCE: return PH_ZERO;
         PH_ZERO:   return PH_COLLIDE;
         default:   return PH_STREAM;
      endcase
   endfunction

endpackage

// File: rtl/lbm_phase_sequencer_cell_counter.sv
// Lattice cell walker: linear index plus separate row/col counters, so
// coordinates never need a divide. Wraps to cell 0 after the last cell.
module lbm_cell_counter
   import lbm_phase_sequencer_pkg::*;
#(
   parameter  int WIDTH  = LBM_WIDTH,
   parameter  int HEIGHT = LBM_HEIGHT,
   localparam int ADDR_W = clog2_min1(WIDTH * HEIGHT),
   localparam int ROW_W  = clog2_min1(HEIGHT),
   localparam int COL_W  = clog2_min1(WIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              advance_i,
   output logic [ADDR_W-1:0] index_o,
   output logic [ROW_W-1:0]  row_o,
   output logic [COL_W-1:0]  col_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] index_q, index_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              col_last_s;

   assign col_last_s = (col_q == COL_W'(WIDTH - 1));
   assign last_o     = col_last_s && (row_q == ROW_W'(HEIGHT - 1));
   assign index_o    = index_q;
   assign row_o      = row_q;
   assign col_o      = col_q;

   always_comb begin
      index_d = index_q;
      row_d   = row_q;
      col_d   = col_q;
      if (clear_i || (advance_i && last_o)) begin
         index_d = {ADDR_W{1'b0}};
         row_d   = {ROW_W{1'b0}};
         col_d   = {COL_W{1'b0}};
      end else if (advance_i) begin
         index_d = index_q + ADDR_W'(1);
         if (col_last_s) begin
            col_d = {COL_W{1'b0}};
            row_d = row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end else begin
         index_d = index_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_q <= {ADDR_W{1'b0}};
         row_q   <= {ROW_W{1'b0}};
         col_q   <= {COL_W{1'b0}};
      end else begin
         index_q <= index_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

endmodule

// File: rtl/lbm_phase_sequencer.sv
// LBM timestep sequencer: sweeps STREAM/BOUNCE/ZERO/COLLIDE over the lattice
// with a drain after each phase. Optional LBM_BARRIER_SKIP_EN skips fluid cells
// in BOUNCE and ZERO.
module lbm_phase_sequencer
   import lbm_phase_sequencer_pkg::*;
#(
   parameter  int WIDTH         = LBM_WIDTH,
   parameter  int HEIGHT        = LBM_HEIGHT,
   parameter  int STEP_W        = 16,
   localparam int DEPTH         = WIDTH * HEIGHT,
   localparam int ADDRESS_WIDTH = clog2_min1(DEPTH),
   localparam int ROW_W         = clog2_min1(HEIGHT),
   localparam int COL_W         = clog2_min1(WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [STEP_W-1:0]        num_steps,
   input  logic                     dp_ready,
   input  logic                     dp_idle,
   input  logic                     barrier_in,
   output logic                     busy,
   output logic                     done,
   output logic [2:0]               phase,
   output logic                     cell_valid,
   output logic [ADDRESS_WIDTH-1:0] cell_index,
   output logic [ROW_W-1:0]         row,
   output logic [COL_W-1:0]         col,
   output logic                     at_top,
   output logic                     at_bottom,
   output logic                     at_left,
   output logic                     at_right,
   output logic [STEP_W-1:0]        step_count
);

   phase_e            phase_q, phase_d;
   logic              drain_q, drain_d;
   logic              done_q, done_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [STEP_W-1:0] nsteps_q, nsteps_d;
   logic [STEP_W-1:0] step_inc_s;
   logic              sweeping_s, skip_s, advance_s, clear_s, last_s;

   assign sweeping_s = (phase_q != PH_IDLE) && !drain_q;

`ifdef LBM_BARRIER_SKIP_EN
   // Fluid cells in BOUNCE/ZERO have nothing to do; step past them unhandshaken.
   assign skip_s = sweeping_s && ((phase_q == PH_BOUNCE) || (phase_q == PH_ZERO)) && !barrier_in;
`else
   logic unused_barrier_s;
   assign unused_barrier_s = barrier_in;
   assign skip_s           = 1'b0;
`endif

   assign cell_valid = sweeping_s && !skip_s;
   assign advance_s  = skip_s || (cell_valid && dp_ready);
   assign step_inc_s = step_q + STEP_W'(1);

   lbm_cell_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_cell_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (clear_s),
      .advance_i (advance_s),
      .index_o   (cell_index),
      .row_o     (row),
      .col_o     (col),
      .last_o    (last_s)
   );

   always_comb begin
      phase_d  = phase_q;
      drain_d  = drain_q;
      done_d   = 1'b0;
      step_d   = step_q;
      nsteps_d = nsteps_q;
      clear_s  = 1'b0;
      case (phase_q)
         PH_IDLE: begin
            if (start) begin
               clear_s  = 1'b1;
               step_d   = {STEP_W{1'b0}};
               nsteps_d = num_steps;
               if (num_steps == {STEP_W{1'b0}}) begin
                  done_d = 1'b1;
               end else begin
                  phase_d = PH_STREAM;
               end
            end else begin
               phase_d = PH_IDLE;
            end
         end
         PH_STREAM, PH_BOUNCE, PH_ZERO, PH_COLLIDE: begin
            if (drain_q) begin
               if (dp_idle) begin
                  drain_d = 1'b0;
                  phase_d = next_phase(phase_q);
                  if (phase_q == PH_COLLIDE) begin
                     step_d = step_inc_s;
                     if (step_inc_s == nsteps_q) begin
                        phase_d = PH_IDLE;
                        done_d  = 1'b1;
                     end else begin
                        phase_d = PH_STREAM;
                     end
                  end else begin
                     step_d = step_q;
                  end
               end else begin
                  drain_d = 1'b1;
               end
            end else if (advance_s && last_s) begin
               drain_d = 1'b1;
            end else begin
               drain_d = 1'b0;
            end
         end
         default: begin
            phase_d = PH_IDLE;
            drain_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= PH_IDLE;
         drain_q  <= 1'b0;
         done_q   <= 1'b0;
         step_q   <= {STEP_W{1'b0}};
         nsteps_q <= {STEP_W{1'b0}};
      end else begin
         phase_q  <= phase_d;
         drain_q  <= drain_d;
         done_q   <= done_d;
         step_q   <= step_d;
         nsteps_q <= nsteps_d;
      end
   end

   assign phase      = phase_q;
   assign busy       = (phase_q != PH_IDLE);
   assign done       = done_q;
   assign step_count = step_q;
   assign at_top     = (row == ROW_W'(0));
   assign at_bottom  = (row == ROW_W'(HEIGHT - 1));
   assign at_left    = (col == COL_W'(0));
   assign at_right   = (col == COL_W'(WIDTH - 1));

endmodule

// File: tb/tb_lbm_phase_sequencer.sv
// Self-checking bench for lbm_phase_sequencer on a 4x3 lattice: directed
// timeline table, corner sequences and a randomized scoreboard run.
module tb_lbm_phase_sequencer;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int D  = W * H;
   localparam int SW = 16;
   localparam int AW = 4;
   localparam int RW = 2;
   localparam int CW = 2;
`ifdef LBM_BARRIER_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, start, dp_ready, dp_idle, barrier_in;
   logic [SW-1:0] num_steps;
   logic          busy, done, cell_valid, at_top, at_bottom, at_left, at_right;
   logic [2:0]    phase;
   logic [AW-1:0] cell_index;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic [SW-1:0] step_count;
   logic [D-1:0]  bar_map;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            cyc;
      logic [2:0]    ph;
      logic          vld;
      logic [AW-1:0] idx;
      logic          bsy;
      logic          dn;
      logic [SW-1:0] stp;
   } tvec_t;

   typedef struct packed {
      logic [2:0] ph;
      logic [7:0] idx;
   } hs_t;

   tvec_t      tbl [16];
   logic [2:0] r_ph  [60];
   logic       r_vld [60];
   logic       r_bsy [60];
   logic       r_dn  [60];
   logic [AW-1:0] r_idx [60];
   logic [SW-1:0] r_stp [60];
   logic [7:0]    r_geo [60];

   always #5 clk = ~clk;
   assign barrier_in = bar_map[cell_index];

   lbm_phase_sequencer #(
      .WIDTH  (W),
      .HEIGHT (H),
      .STEP_W (SW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_steps  (num_steps),
      .dp_ready   (dp_ready),
      .dp_idle    (dp_idle),
      .barrier_in (barrier_in),
      .busy       (busy),
      .done       (done),
      .phase      (phase),
      .cell_valid (cell_valid),
      .cell_index (cell_index),
      .row        (row),
      .col        (col),
      .at_top     (at_top),
      .at_bottom  (at_bottom),
      .at_left    (at_left),
      .at_right   (at_right),
      .step_count (step_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Expected handshake view of a cell, from plain arithmetic on the index.
   function automatic logic [63:0] exp_hs(input logic [2:0] ph, input int idx);
      int r, c;
      r = idx / W;
      c = idx % W;
      return {49'd0, ph, AW'(idx), RW'(r), CW'(c), (r == 0), (r == H - 1), (c == 0), (c == W - 1)};
   endfunction

   function automatic logic [63:0] act_hs();
      return {49'd0, phase, cell_index, row, col, at_top, at_bottom, at_left, at_right};
   endfunction

   task automatic random_run(input int n);
      hs_t  exp_q[$];
      hs_t  e;
      bit   pv, finished;
      logic [AW-1:0] pidx;
      bar_map = D'($urandom);
      for (int s = 0; s < n; s++)
         for (int p = 1; p <= 4; p++)
            for (int i = 0; i < D; i++)
               if (!SKIP || p == 1 || p == 4 || bar_map[i])
                  exp_q.push_back('{ph: 3'(p), idx: 8'(i)});
      num_steps = SW'(n);
      start     = 1'b1;
      cyc();
      start     = 1'b0;
      pv        = 1'b0;
      pidx      = '0;
      finished  = 1'b0;
      for (int b = 0; b < 3000 && !finished; b++) begin
         dp_ready  = ($urandom_range(0, 3) != 0);
         dp_idle   = ($urandom_range(0, 2) == 0);
         start     = ($urandom_range(0, 7) == 0);
         num_steps = SW'($urandom);
         #1;
         if (pv) chk("stall_hold", {cell_valid, cell_index}, {1'b1, pidx});
         if (done) begin
            start    = 1'b0;
            finished = 1'b1;
            chk("rand_done_busy", busy, 1'b0);
            chk("rand_done_steps", step_count, SW'(n));
            chk("rand_all_cells", exp_q.size(), 0);
         end else begin
            chk("rand_busy", busy, 1'b1);
            if (cell_valid && dp_ready) begin
               if (exp_q.size() == 0) begin
                  chk("rand_extra_hs", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rand_hs", act_hs(), exp_hs(e.ph, int'(e.idx)));
               end
            end
            pv   = cell_valid && !dp_ready;
            pidx = cell_index;
            cyc();
         end
      end
      if (!finished) chk("rand_timeout", 1'b0, 1'b1);
      cyc();
      chk("rand_done_pulse", done, 1'b0);
      chk("rand_step_hold", step_count, SW'(n));
      dp_ready = 1'b1;
      dp_idle  = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      bit acc;
      int cnt [5];

      rst_n = 1'b0; start = 1'b0; num_steps = '0;
      dp_ready = 1'b1; dp_idle = 1'b1; bar_map = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {phase, busy, done, cell_valid, cell_index, row, col, step_count},
          '0);
      rst_n = 1'b1;
      cyc();

      // Full one-step timeline with an always-ready datapath.
      tbl[0]  = '{0,  3'd0, 1'b0, 4'd0,  1'b0, 1'b0, 16'd0};
      tbl[1]  = '{1,  3'd1, 1'b1, 4'd0,  1'b1, 1'b0, 16'd0};
      tbl[2]  = '{6,  3'd1, 1'b1, 4'd5,  1'b1, 1'b0, 16'd0};
      tbl[3]  = '{12, 3'd1, 1'b1, 4'd11, 1'b1, 1'b0, 16'd0};
      tbl[4]  = '{13, 3'd1, 1'b0, 4'd0,  1'b1, 1'b0, 16'd0};
      tbl[5]  = '{14, 3'd2, 1'b1, 4'd0,  1'b1, 1'b0, 16'd0};
      tbl[6]  = '{25, 3'd2, 1'b1, 4'd11, 1'b1, 1'b0, 16'd0};
      tbl[7]  = '{26, 3'd2, 1'b0, 4'd0,  1'b1, 1'b0, 16'd0};
      tbl[8]  = '{27, 3'd3, 1'b1, 4'd0,  1'b1, 1'b0, 16'd0};
      tbl[9]  = '{38, 3'd3, 1'b1, 4'd11, 1'b1, 1'b0, 16'd0};
      tbl[10] = '{39, 3'd3, 1'b0, 4'd0,  1'b1, 1'b0, 16'd0};
      tbl[11] = '{40, 3'd4, 1'b1, 4'd0,  1'b1, 1'b0, 16'd0};
      tbl[12] = '{51, 3'd4, 1'b1, 4'd11, 1'b1, 1'b0, 16'd0};
      tbl[13] = '{52, 3'd4, 1'b0, 4'd0,  1'b1, 1'b0, 16'd0};
      tbl[14] = '{53, 3'd0, 1'b0, 4'd0,  1'b0, 1'b1, 16'd1};
      tbl[15] = '{54, 3'd0, 1'b0, 4'd0,  1'b0, 1'b0, 16'd1};

      num_steps = 16'd1;
      start     = 1'b1;
      for (int c = 0; c < 60; c++) begin
         r_ph[c] = phase; r_vld[c] = cell_valid; r_bsy[c] = busy; r_dn[c] = done;
         r_idx[c] = cell_index; r_stp[c] = step_count;
         r_geo[c] = {row, col, at_top, at_bottom, at_left, at_right};
         cyc();
         start = 1'b0;
      end
      for (int t = 0; t < 16; t++) begin
         chk($sformatf("timeline_c%0d", tbl[t].cyc),
             {r_ph[tbl[t].cyc], r_vld[tbl[t].cyc], r_bsy[tbl[t].cyc], r_dn[tbl[t].cyc], r_stp[tbl[t].cyc]},
             {tbl[t].ph, tbl[t].vld, tbl[t].bsy, tbl[t].dn, tbl[t].stp});
         if (tbl[t].vld) chk($sformatf("timeline_idx_c%0d", tbl[t].cyc), r_idx[tbl[t].cyc], tbl[t].idx);
      end
      chk("geometry_cell7", {r_idx[8], r_geo[8]}, {4'd7, 2'd1, 2'd3, 4'b0001});

      // num_steps = 0 finishes immediately without touching the lattice.
      num_steps = 16'd0;
      start     = 1'b1;
      cyc();
      start     = 1'b0;
      chk("zero_steps_done", {done, busy, cell_valid, step_count}, {1'b1, 1'b0, 1'b0, 16'd0});
      acc = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         acc = acc | done | busy | cell_valid;
      end
      chk("zero_steps_quiet", acc, 1'b0);

      // Stall on cell 5 for three cycles.
      num_steps = 16'd1;
      start     = 1'b1;
      cyc();
      start     = 1'b0;
      found     = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         if (cell_valid && cell_index == 4'd5) found = 1'b1;
         else cyc();
      end
      chk("wait_cell5", found, 1'b1);
      dp_ready = 1'b0;
      chk("stall_c0", {cell_valid, cell_index}, {1'b1, 4'd5});
      for (int k = 1; k <= 3; k++) begin
         cyc();
         if (k == 3) dp_ready = 1'b1;
         chk($sformatf("stall_c%0d", k), {cell_valid, cell_index}, {1'b1, 4'd5});
      end
      cyc();
      chk("stall_release", {cell_valid, cell_index}, {1'b1, 4'd6});

      // Asynchronous reset in the middle of BOUNCE.
      found = 1'b0;
      for (int k = 0; k < 80 && !found; k++) begin
         if (phase == 3'd2 && cell_index == 4'd6 && cell_valid) found = 1'b1;
         else cyc();
      end
      chk("wait_bounce6", found, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", {phase, busy, done, cell_valid, cell_index, row, col, step_count}, '0);
      repeat (2) cyc();
      rst_n = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 15; k++) begin
         cyc();
         acc = acc | busy | done | cell_valid | (phase != 3'd0) | (cell_index != 4'd0);
      end
      chk("idle_after_reset", acc, 1'b0);

      // Randomized runs against the scoreboard.
      for (int r = 0; r < 5; r++) random_run(1 + (r % 3));

`ifdef LBM_BARRIER_SKIP_EN
      bar_map   = 12'h020;
      dp_ready  = 1'b1;
      dp_idle   = 1'b1;
      num_steps = 16'd1;
      for (int p = 0; p < 5; p++) cnt[p] = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 120 && !found; k++) begin
         if (done) found = 1'b1;
         else begin
            if (cell_valid) begin
               cnt[phase]++;
               if (phase == 3'd2 || phase == 3'd3) chk("skip_barrier_idx", cell_index, 4'd5);
            end
            cyc();
         end
      end
      chk("skip_done", found, 1'b1);
      chk("skip_counts", {cnt[1][7:0], cnt[2][7:0], cnt[3][7:0], cnt[4][7:0]},
          {8'd12, 8'd1, 8'd1, 8'd12});
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
